// File: rtl/ex_stage_fwd_mc.sv
// Execute stage with EX/MEM and MEM/WB operand forwarding, a single-cycle ALU
// and an iterative shift-add multiplier. The output register is the EX/MEM
// pipeline register. stall_o holds upstream while a multiply is in flight.
module ex_stage_fwd_mc #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [3:0]        aluop_i,
    input  logic [DATA_W-1:0] alusrc1_i,
    input  logic [DATA_W-1:0] alusrc2_i,
    input  logic [REG_AW-1:0] regsrc1_i,
    input  logic [REG_AW-1:0] regsrc2_i,
    input  logic              fwd1_en_i,
    input  logic              fwd2_en_i,
    input  logic [REG_AW-1:0] regsrc_sw_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [REG_AW-1:0] regdst_i,
    input  logic              regwrite_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [REG_AW-1:0] exregdst_i,
    input  logic              exregwrite_i,
    input  logic [DATA_W-1:0] exregdata_i,
    input  logic [REG_AW-1:0] memregdst_i,
    input  logic              memregwrite_i,
    input  logic [DATA_W-1:0] memregdata_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] alures_o,
    output logic [DATA_W-1:0] memdata_o,
    output logic [REG_AW-1:0] regdst_o,
    output logic              regwrite_o,
    output logic              memread_o,
    output logic              memwrite_o
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_PASA = 4'hC;
    localparam logic [3:0] OP_PASB = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // Newest producer wins: EX/MEM before MEM/WB before the ID value.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic              en,
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] id_val,
        input logic              ex_wr,
        input logic [REG_AW-1:0] ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              mem_wr,
        input logic [REG_AW-1:0] mem_dst,
        input logic [DATA_W-1:0] mem_val
    );
        logic [DATA_W-1:0] sel;
        if (en && ex_wr && (ex_dst == src)) begin
            sel = ex_val;
        end else if (en && mem_wr && (mem_dst == src)) begin
            sel = mem_val;
        end else begin
            sel = id_val;
        end
        return sel;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SH_W-1:0]   r_cnt;
    logic [DATA_W-1:0] r_mcand, r_mplier, r_acc;
    logic [DATA_W-1:0] r_m_memdata;
    logic [REG_AW-1:0] r_m_regdst;
    logic              r_m_regwrite, r_m_memread, r_m_memwrite;

    logic              r_valid, r_regwrite, r_memread, r_memwrite;
    logic [DATA_W-1:0] r_alures, r_memdata;
    logic [REG_AW-1:0] r_regdst;

    logic [DATA_W-1:0] w_op_a, w_op_b, w_st_data, w_alu_res, w_partial;
    logic [SH_W-1:0]   w_shamt;
    logic              w_capture, w_step;
    logic              w_ld_valid, w_ld_rw, w_ld_mr, w_ld_mw;
    logic [DATA_W-1:0] w_ld_res, w_ld_memdata;
    logic [REG_AW-1:0] w_ld_regdst;

    assign w_op_a    = fwd_sel(fwd1_en_i, regsrc1_i, alusrc1_i, exregwrite_i, exregdst_i,
                               exregdata_i, memregwrite_i, memregdst_i, memregdata_i);
    assign w_op_b    = fwd_sel(fwd2_en_i, regsrc2_i, alusrc2_i, exregwrite_i, exregdst_i,
                               exregdata_i, memregwrite_i, memregdst_i, memregdata_i);
    assign w_st_data = fwd_sel(memwrite_i, regsrc_sw_i, memdata_i, exregwrite_i, exregdst_i,
                               exregdata_i, memregwrite_i, memregdst_i, memregdata_i);
    assign w_shamt   = w_op_b[SH_W-1:0];
    assign w_partial = r_acc + (r_mplier[0] ? r_mcand : {DATA_W{1'b0}});

    // Single-cycle ALU on the forwarded operands; MUL is produced by the iterative unit.
    always_comb begin
        w_alu_res = {DATA_W{1'b0}};
        case (aluop_i)
            OP_ADD:  w_alu_res = w_op_a + w_op_b;
            OP_SUB:  w_alu_res = w_op_a - w_op_b;
            OP_AND:  w_alu_res = w_op_a & w_op_b;
            OP_OR:   w_alu_res = w_op_a | w_op_b;
            OP_XOR:  w_alu_res = w_op_a ^ w_op_b;
            OP_NOT:  w_alu_res = ~w_op_a;
            OP_SLL:  w_alu_res = w_op_a << w_shamt;
            OP_SRL:  w_alu_res = w_op_a >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            OP_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (w_op_a < w_op_b)};
            OP_CMP:  w_alu_res = {{(DATA_W-1){1'b0}}, (w_op_a != w_op_b)};
            OP_PASA: w_alu_res = w_op_a;
            OP_PASB: w_alu_res = w_op_b;
            default: w_alu_res = {DATA_W{1'b0}};
        endcase
    end

    // FSM next state, upstream stall and the value to load into the EX/MEM register.
    always_comb begin
        w_state_nxt  = r_state;
        stall_o      = 1'b0;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_ld_valid   = 1'b0;
        w_ld_res     = {DATA_W{1'b0}};
        w_ld_memdata = {DATA_W{1'b0}};
        w_ld_regdst  = {REG_AW{1'b0}};
        w_ld_rw      = 1'b0;
        w_ld_mr      = 1'b0;
        w_ld_mw      = 1'b0;
        if (rst || flush_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i && (aluop_i == OP_MUL)) begin
                        stall_o     = 1'b1;
                        w_capture   = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else if (valid_i) begin
                        w_ld_valid   = 1'b1;
                        w_ld_res     = w_alu_res;
                        w_ld_memdata = w_st_data;
                        w_ld_regdst  = regdst_i;
                        w_ld_rw      = regwrite_i;
                        w_ld_mr      = memread_i;
                        w_ld_mw      = memwrite_i;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt  = ST_IDLE;
                        w_ld_valid   = 1'b1;
                        w_ld_res     = w_partial;
                        w_ld_memdata = r_m_memdata;
                        w_ld_regdst  = r_m_regdst;
                        w_ld_rw      = r_m_regwrite;
                        w_ld_mr      = r_m_memread;
                        w_ld_mw      = r_m_memwrite;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register, multiplier datapath and the EX/MEM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {SH_W{1'b0}};
            r_mcand      <= {DATA_W{1'b0}};
            r_mplier     <= {DATA_W{1'b0}};
            r_acc        <= {DATA_W{1'b0}};
            r_m_memdata  <= {DATA_W{1'b0}};
            r_m_regdst   <= {REG_AW{1'b0}};
            r_m_regwrite <= 1'b0;
            r_m_memread  <= 1'b0;
            r_m_memwrite <= 1'b0;
            r_valid      <= 1'b0;
            r_alures     <= {DATA_W{1'b0}};
            r_memdata    <= {DATA_W{1'b0}};
            r_regdst     <= {REG_AW{1'b0}};
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_ld_valid;
            r_alures   <= w_ld_res;
            r_memdata  <= w_ld_memdata;
            r_regdst   <= w_ld_regdst;
            r_regwrite <= w_ld_rw;
            r_memread  <= w_ld_mr;
            r_memwrite <= w_ld_mw;
            if (w_capture) begin
                r_mcand      <= w_op_a;
                r_mplier     <= w_op_b;
                r_acc        <= {DATA_W{1'b0}};
                r_cnt        <= {SH_W{1'b0}};
                r_m_memdata  <= w_st_data;
                r_m_regdst   <= regdst_i;
                r_m_regwrite <= regwrite_i;
                r_m_memread  <= memread_i;
                r_m_memwrite <= memwrite_i;
            end else if (w_step) begin
                r_acc    <= w_partial;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + SH_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign valid_o    = r_valid;
    assign alures_o   = r_alures;
    assign memdata_o  = r_memdata;
    assign regdst_o   = r_regdst;
    assign regwrite_o = r_regwrite;
    assign memread_o  = r_memread;
    assign memwrite_o = r_memwrite;

endmodule

// File: tb/tb_ex_stage_fwd_mc.sv
// Scoreboard bench for ex_stage_fwd_mc: a driver issues instructions and
// queues the expected EX/MEM contents with the edge they must appear on; a
// monitor compares every output edge against the queue.
module tb_ex_stage_fwd_mc;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid_i, flush_i, fwd1_en_i, fwd2_en_i, regwrite_i, memread_i, memwrite_i;
    logic exregwrite_i, memregwrite_i;
    logic [3:0] aluop_i;
    logic [DW-1:0] alusrc1_i, alusrc2_i, memdata_i, exregdata_i, memregdata_i;
    logic [AW-1:0] regsrc1_i, regsrc2_i, regsrc_sw_i, regdst_i, exregdst_i, memregdst_i;
    logic stall_o, valid_o, regwrite_o, memread_o, memwrite_o;
    logic [DW-1:0] alures_o, memdata_o;
    logic [AW-1:0] regdst_o;

    ex_stage_fwd_mc #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
        .alusrc1_i(alusrc1_i), .alusrc2_i(alusrc2_i), .regsrc1_i(regsrc1_i),
        .regsrc2_i(regsrc2_i), .fwd1_en_i(fwd1_en_i), .fwd2_en_i(fwd2_en_i),
        .regsrc_sw_i(regsrc_sw_i), .memdata_i(memdata_i), .regdst_i(regdst_i),
        .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .exregdst_i(exregdst_i), .exregwrite_i(exregwrite_i), .exregdata_i(exregdata_i),
        .memregdst_i(memregdst_i), .memregwrite_i(memregwrite_i), .memregdata_i(memregdata_i),
        .stall_o(stall_o), .valid_o(valid_o), .alures_o(alures_o), .memdata_o(memdata_o),
        .regdst_o(regdst_o), .regwrite_o(regwrite_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o)
    );

    typedef struct {
        logic v; logic [3:0] op; logic [DW-1:0] a, b; logic [AW-1:0] rs1, rs2;
        logic f1, f2; logic [AW-1:0] rsw; logic [DW-1:0] md; logic [AW-1:0] rd;
        logic rw, mr, mw; logic [AW-1:0] exd; logic exw; logic [DW-1:0] exv;
        logic [AW-1:0] mmd; logic mmw; logic [DW-1:0] mmv;
        logic gold_en; logic [DW-1:0] gold;
    } ins_t;

    typedef struct {
        int edge_n; logic [DW-1:0] res, md; logic [AW-1:0] rd; logic rw, mr, mw;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fwd_ref(input logic en, input logic [AW-1:0] src,
            input logic [DW-1:0] idv, input ins_t in);
        if (en && in.exw && in.exd == src) return in.exv;
        if (en && in.mmw && in.mmd == src) return in.mmv;
        return idv;
    endfunction

    // Reference ALU written with plain integer arithmetic.
    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
            input logic [DW-1:0] b);
        int unsigned ua, ub, sh;
        int sa, sbv;
        ua = a; ub = b; sh = ub % DW;
        sa = $signed(a); sbv = $signed(b);
        case (op)
            4'h0: return DW'(ua + ub);
            4'h1: return DW'(ua - ub);
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return DW'(ua * (32'd1 << sh));
            4'h7: return DW'(ua / (32'd1 << sh));
            4'h8: return DW'(sa >>> sh);
            4'h9: return (sa < sbv) ? 16'd1 : 16'd0;
            4'hA: return (ua < ub) ? 16'd1 : 16'd0;
            4'hB: return (ua == ub) ? 16'd0 : 16'd1;
            4'hC: return a;
            4'hD: return b;
            4'hE: return DW'(ua * ub);
            default: return 16'd0;
        endcase
    endfunction

    function automatic ins_t blank_ins();
        ins_t in;
        in.v = 1'b1; in.op = 4'h0; in.a = 16'd0; in.b = 16'd0; in.rs1 = 4'd0; in.rs2 = 4'd0;
        in.f1 = 1'b0; in.f2 = 1'b0; in.rsw = 4'd0; in.md = 16'd0; in.rd = 4'd1;
        in.rw = 1'b1; in.mr = 1'b0; in.mw = 1'b0; in.exd = 4'd0; in.exw = 1'b0;
        in.exv = 16'd0; in.mmd = 4'd0; in.mmw = 1'b0; in.mmv = 16'd0;
        in.gold_en = 1'b0; in.gold = 16'd0;
        return in;
    endfunction

    function automatic ins_t rand_ins();
        ins_t in;
        in = blank_ins();
        in.v = ($urandom_range(0, 7) != 0);
        in.op = 4'($urandom_range(0, 15));
        if (in.op == 4'hE && $urandom_range(0, 1) == 0) in.op = 4'hD;
        in.a = 16'($urandom); in.b = 16'($urandom); in.md = 16'($urandom);
        in.rs1 = 4'($urandom_range(0, 3)); in.rs2 = 4'($urandom_range(0, 3));
        in.rsw = 4'($urandom_range(0, 3)); in.rd = 4'($urandom);
        in.f1 = 1'($urandom); in.f2 = 1'($urandom);
        in.rw = 1'($urandom); in.mr = 1'($urandom); in.mw = 1'($urandom);
        in.exd = 4'($urandom_range(0, 3)); in.exw = 1'($urandom); in.exv = 16'($urandom);
        in.mmd = 4'($urandom_range(0, 3)); in.mmw = 1'($urandom); in.mmv = 16'($urandom);
        return in;
    endfunction

    task automatic drive(input ins_t in);
        valid_i = in.v; aluop_i = in.op; alusrc1_i = in.a; alusrc2_i = in.b;
        regsrc1_i = in.rs1; regsrc2_i = in.rs2; fwd1_en_i = in.f1; fwd2_en_i = in.f2;
        regsrc_sw_i = in.rsw; memdata_i = in.md; regdst_i = in.rd; regwrite_i = in.rw;
        memread_i = in.mr; memwrite_i = in.mw; exregdst_i = in.exd; exregwrite_i = in.exw;
        exregdata_i = in.exv; memregdst_i = in.mmd; memregwrite_i = in.mmw;
        memregdata_i = in.mmv;
    endtask

    task automatic chk_zero(input string name);
        chk(name, 64'({valid_o, alures_o, memdata_o, regdst_o, regwrite_o, memread_o,
                       memwrite_o}), 64'd0);
    endtask

    // Present one instruction until upstream may advance. kill_at selects the
    // cycle (0 = first) on which flush_i, or rst when kill_rst, is raised.
    task automatic run(input ins_t in, input int kill_at, input bit kill_rst);
        int k;
        bit done, exp_st, is_mul;
        exp_t e;
        logic [DW-1:0] a_f, b_f;
        k = 0; done = 1'b0;
        is_mul = in.v && (in.op == 4'hE);
        a_f = fwd_ref(in.f1, in.rs1, in.a, in);
        b_f = fwd_ref(in.f2, in.rs2, in.b, in);
        e.res = in.gold_en ? in.gold : alu_ref(in.op, a_f, b_f);
        e.md = fwd_ref(in.mw, in.rsw, in.md, in);
        e.rd = in.rd; e.rw = in.rw; e.mr = in.mr; e.mw = in.mw;
        while (!done) begin
            drive(in);
            if (k > 0) begin
                exregdata_i = 16'($urandom); memregdata_i = 16'($urandom);
                alusrc1_i = 16'($urandom); alusrc2_i = 16'($urandom);
            end
            flush_i = (k == kill_at) && !kill_rst;
            rst     = (k == kill_at) && kill_rst;
            @(negedge clk);
            exp_st = is_mul && (k < DW) && (k != kill_at);
            chk("stall_o", 64'(stall_o), 64'(exp_st));
            if (!exp_st) begin
                done = 1'b1;
                if (in.v && k != kill_at) begin
                    e.edge_n = cyc + 1;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            if (k == kill_at && kill_rst) begin
                rst = 1'b0;
                chk_zero("reset_mid_mul");
            end
            k++;
        end
        flush_i = 1'b0;
        rst = 1'b0;
    endtask

    // Monitor: every output edge is either a queued instruction or a clean bubble.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_edge", 64'(cyc), 64'(e.edge_n));
                    chk("alures_o", 64'(alures_o), 64'(e.res));
                    chk("memdata_o", 64'(memdata_o), 64'(e.md));
                    chk("ctrl_o", 64'({regdst_o, regwrite_o, memread_o, memwrite_o}),
                        64'({e.rd, e.rw, e.mr, e.mw}));
                end
            end else begin
                chk("bubble", 64'({valid_o, regwrite_o, memread_o, memwrite_o}), 64'd0);
                if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_valid", 64'(valid_o), 64'd1);
                end
            end
        end
    end

    initial begin
        ins_t in;
        int ka;
        rst = 1'b1; flush_i = 1'b0;
        drive(blank_ins());
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            drive(rand_ins());
            rst = 1'b1;
            flush_i = 1'($urandom);
            @(negedge clk);
            chk("stall_in_reset", 64'(stall_o), 64'd0);
            if (i > 0) chk_zero("reset_outputs");
            @(posedge clk); #1;
        end
        chk_zero("reset_outputs");
        rst = 1'b0; flush_i = 1'b0;
        mon_en = 1'b1;

        in = blank_ins(); in.v = 1'b0;
        for (int i = 0; i < 3; i++) run(in, -1, 1'b0);

        // Forwarding: A and B from ID, store data from MEM/WB.
        in = blank_ins();
        in.a = 16'hFFF1; in.b = 16'h001F; in.rs1 = 4'h5; in.rs2 = 4'hF; in.f1 = 1'b1;
        in.f2 = 1'b1; in.exd = 4'hF; in.exw = 1'b0; in.mmd = 4'h4; in.mmw = 1'b1;
        in.mmv = 16'hF0F0; in.mw = 1'b1; in.rsw = 4'h4; in.md = 16'h0F0F;
        in.gold_en = 1'b1; in.gold = 16'h0010;
        run(in, -1, 1'b0);

        // EX/MEM beats MEM/WB; no forwarding when disabled.
        in = blank_ins();
        in.rs1 = 4'h5; in.f1 = 1'b1; in.exd = 4'h5; in.exw = 1'b1; in.exv = 16'h0003;
        in.mmd = 4'h5; in.mmw = 1'b1; in.mmv = 16'h0007; in.a = 16'hFFFF; in.b = 16'h0001;
        in.gold_en = 1'b1; in.gold = 16'h0004;
        run(in, -1, 1'b0);
        in.f1 = 1'b0; in.gold = 16'h0000;
        run(in, -1, 1'b0);

        // Multiply followed by an ADD held upstream.
        in = blank_ins(); in.op = 4'hE; in.a = 16'h0123; in.b = 16'h0010;
        in.gold_en = 1'b1; in.gold = 16'h1230;
        run(in, -1, 1'b0);
        in = blank_ins(); in.a = 16'h0001; in.b = 16'h0001; in.gold_en = 1'b1;
        in.gold = 16'h0002;
        run(in, -1, 1'b0);

        // Flush on the 5th busy cycle, then reset mid-multiply.
        in = blank_ins(); in.op = 4'hE; in.a = 16'h00FF; in.b = 16'h00FF;
        run(in, 5, 1'b0);
        in = blank_ins(); in.a = 16'h0005; in.b = 16'h0006; in.gold_en = 1'b1;
        in.gold = 16'h000B;
        run(in, -1, 1'b0);
        in = blank_ins(); in.op = 4'hE; in.a = 16'h00FF; in.b = 16'h00FF;
        run(in, 7, 1'b1);
        in = blank_ins(); in.a = 16'h0100; in.b = 16'h0023; in.gold_en = 1'b1;
        in.gold = 16'h0123;
        run(in, -1, 1'b0);

        // Shifts and compares.
        in = blank_ins(); in.gold_en = 1'b1;
        in.op = 4'h8; in.a = 16'h8000; in.b = 16'h0003; in.gold = 16'hF000; run(in, -1, 1'b0);
        in.op = 4'h6; in.a = 16'h0001; in.b = 16'h000F; in.gold = 16'h8000; run(in, -1, 1'b0);
        in.op = 4'h9; in.a = 16'hFFFF; in.b = 16'h0001; in.gold = 16'h0001; run(in, -1, 1'b0);
        in.op = 4'hA; in.gold = 16'h0000; run(in, -1, 1'b0);
        in.op = 4'hB; in.a = 16'h1234; in.b = 16'h1234; in.gold = 16'h0000; run(in, -1, 1'b0);
        in.op = 4'h5; in.a = 16'h00FF; in.gold = 16'hFF00; run(in, -1, 1'b0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++) begin
            in = rand_ins();
            ka = -1;
            if ($urandom_range(0, 11) == 0) begin
                ka = (in.v && in.op == 4'hE) ? int'($urandom_range(0, DW)) : 0;
            end
            run(in, ka, 1'b0);
        end

        in = blank_ins(); in.v = 1'b0;
        for (int i = 0; i < 3; i++) run(in, -1, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
